// File: rtl/fwd_pkg.sv
// fwd_pkg: shared forwarding-select and stall-cause encodings plus register address width
package fwd_pkg;
  localparam int REG_AW = 5;
  localparam logic [1:0] FWD_HOLD = 2'b00;
  localparam logic [1:0] FWD_RF = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB = 2'b11;
  typedef enum logic [1:0] {ST_IDLE = 2'b00, ST_LU = 2'b01, ST_SB = 2'b10} cause_e;
endpackage

// File: rtl/fwd_src_sel.sv
// fwd_src_sel: per-source forward select (src, MEM/WB write ports, hold entry in; sel out), priority MEM > WB > HOLD > RF
module fwd_src_sel
  import fwd_pkg::*;
(
  input  logic [REG_AW-1:0] src,
  input  logic              mem_we,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              hold_v,
  input  logic [REG_AW-1:0] hold_addr,
  output logic [1:0]        sel
);
  always_comb
    sel = (mem_we && mem_rd != '0 && mem_rd == src) ? FWD_MEM :
          (wb_we && wb_rd != '0 && wb_rd == src) ? FWD_WB :
          (hold_v && hold_addr != '0 && hold_addr == src) ? FWD_HOLD : FWD_RF;
endmodule

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: EX operand forwarding (fwd_sel_o, hold_data_o) plus load-use/scoreboard stall control (stall_o, stall_cause_o, sb_full_o, stall_cnt_o)
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int NUM_SRC = 2,
  parameter int XLEN = 32,
  parameter int LL_MAX = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [REG_AW*NUM_SRC-1:0] EX_RSaddr_i,
  input  logic                      MEM_RegWrite_i,
  input  logic [REG_AW-1:0]         MEM_RDaddr_i,
  input  logic                      WB_RegWrite_i,
  input  logic [REG_AW-1:0]         WB_RDaddr_i,
  input  logic [XLEN-1:0]           WB_data_i,
  input  logic [REG_AW*NUM_SRC-1:0] ID_RSaddr_i,
  input  logic [NUM_SRC-1:0]        ID_use_i,
  input  logic                      ID_valid_i,
  input  logic                      ID_ll_i,
  input  logic [REG_AW-1:0]         ID_RDaddr_i,
  input  logic                      EX_MemRead_i,
  input  logic [REG_AW-1:0]         EX_RDaddr_i,
  input  logic                      LL_done_i,
  input  logic [REG_AW-1:0]         LL_RDaddr_i,
  output logic [2*NUM_SRC-1:0]      fwd_sel_o,
  output logic [XLEN-1:0]           hold_data_o,
  output logic                      stall_o,
  output logic [1:0]                stall_cause_o,
  output logic                      sb_full_o,
  output logic [15:0]               stall_cnt_o
);
  logic              hold_v;
  logic [REG_AW-1:0] hold_addr;
  logic [31:0]       pending;
  logic [5:0]        pcount;
  logic              lu_hit, src_pend, sb_hit, issue, wb_ok;
  cause_e            state;
  for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
    fwd_src_sel u_sel (
      .src      (EX_RSaddr_i[REG_AW*k +: REG_AW]),
      .mem_we   (MEM_RegWrite_i),
      .mem_rd   (MEM_RDaddr_i),
      .wb_we    (WB_RegWrite_i),
      .wb_rd    (WB_RDaddr_i),
      .hold_v   (hold_v),
      .hold_addr(hold_addr),
      .sel      (fwd_sel_o[2*k +: 2])
    );
  end
  always_comb begin
    lu_hit = 1'b0;
    src_pend = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      lu_hit |= ID_use_i[k] && ID_RSaddr_i[REG_AW*k +: REG_AW] == EX_RDaddr_i;
      src_pend |= ID_use_i[k] && pending[ID_RSaddr_i[REG_AW*k +: REG_AW]];
    end
    lu_hit &= EX_MemRead_i && EX_RDaddr_i != '0;
  end
  always_comb begin
    pcount = '0;
    for (int i = 1; i < 32; i++) pcount += {5'd0, pending[i]};
  end
  assign sb_full_o = pcount == 6'(LL_MAX);
  assign sb_hit = ID_valid_i && (src_pend || (ID_ll_i && (pending[ID_RDaddr_i] || sb_full_o)));
  assign stall_o = ID_valid_i && (lu_hit || sb_hit);
  assign issue = ID_valid_i && ID_ll_i && !stall_o && ID_RDaddr_i != '0;
  assign wb_ok = WB_RegWrite_i && WB_RDaddr_i != '0;
  assign stall_cause_o = state;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hold_v <= 1'b0;
      hold_addr <= '0;
      hold_data_o <= '0;
      pending <= '0;
      state <= ST_IDLE;
      stall_cnt_o <= '0;
    end else begin
      hold_v <= wb_ok;
      if (wb_ok) begin
        hold_addr <= WB_RDaddr_i;
        hold_data_o <= WB_data_i;
      end
      // clear first so a same-cycle issue to the same rd leaves the bit set
      if (LL_done_i) pending[LL_RDaddr_i] <= 1'b0;
      if (issue) pending[ID_RDaddr_i] <= 1'b1;
      state <= state == ST_LU ? ST_IDLE : lu_hit ? ST_LU : sb_hit ? ST_SB : ST_IDLE;
      if (stall_o && stall_cnt_o != 16'hFFFF) stall_cnt_o <= stall_cnt_o + 16'd1;
    end
  end
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb_fwd_hazard_unit: directed self-checking bench for fwd_hazard_unit
module tb_fwd_hazard_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  ex_rs, id_rs;
  logic        mem_we, wb_we, id_valid, id_ll, ex_mr, ll_done;
  logic [4:0]  mem_rd, wb_rd, id_rd, ex_rd, ll_rd;
  logic [31:0] wb_data;
  logic [1:0]  id_use;
  logic [3:0]  fwd_sel;
  logic [31:0] hold_data;
  logic        stall, sb_full;
  logic [1:0]  cause;
  logic [15:0] cnt;
  int          passed = 0, total = 0;
  fwd_hazard_unit dut (
    .clk_i(clk), .rst_i(rst), .EX_RSaddr_i(ex_rs),
    .MEM_RegWrite_i(mem_we), .MEM_RDaddr_i(mem_rd),
    .WB_RegWrite_i(wb_we), .WB_RDaddr_i(wb_rd), .WB_data_i(wb_data),
    .ID_RSaddr_i(id_rs), .ID_use_i(id_use), .ID_valid_i(id_valid),
    .ID_ll_i(id_ll), .ID_RDaddr_i(id_rd),
    .EX_MemRead_i(ex_mr), .EX_RDaddr_i(ex_rd),
    .LL_done_i(ll_done), .LL_RDaddr_i(ll_rd),
    .fwd_sel_o(fwd_sel), .hold_data_o(hold_data), .stall_o(stall),
    .stall_cause_o(cause), .sb_full_o(sb_full), .stall_cnt_o(cnt)
  );
  always #5 clk = ~clk;
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask
  initial begin
    rst = 1; ex_rs = '0; id_rs = '0; mem_we = 0; wb_we = 0; id_valid = 0; id_ll = 0;
    ex_mr = 0; ll_done = 0; mem_rd = '0; wb_rd = '0; id_rd = '0; ex_rd = '0; ll_rd = '0;
    wb_data = '0; id_use = '0;
    cyc(); cyc();
    chk("rst_cnt", 32'(cnt), 0);
    chk("rst_full", 32'(sb_full), 0);
    chk("rst_hold", hold_data, 0);
    chk("rst_cause", 32'(cause), 0);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_fwd", 32'(fwd_sel), 32'h5);
    rst = 0;
    ex_rs = 10'd5; mem_we = 1; mem_rd = 5'd5; wb_we = 1; wb_rd = 5'd5; #1;
    chk("fwd_mem", 32'(fwd_sel[1:0]), 2'b10);
    mem_we = 0; #1;
    chk("fwd_wb", 32'(fwd_sel[1:0]), 2'b11);
    mem_we = 1; mem_rd = 5'd0; ex_rs = 10'd0; #1;
    chk("fwd_x0", 32'(fwd_sel[1:0]), 2'b01);
    mem_we = 0; wb_rd = 5'd7; wb_data = 32'hDEADBEEF;
    cyc();
    wb_we = 0; ex_rs = {5'd7, 5'd0}; #1;
    chk("fwd_hold", 32'(fwd_sel[3:2]), 2'b00);
    chk("hold_data", hold_data, 32'hDEADBEEF);
    cyc();
    chk("hold_expire", 32'(fwd_sel[3:2]), 2'b01);
    ex_rs = '0; ex_mr = 1; ex_rd = 5'd3; id_valid = 1; id_use = 2'b01; id_rs = 10'd3; #1;
    chk("lu_stall", 32'(stall), 1);
    chk("lu_cause0", 32'(cause), 0);
    cyc();
    ex_mr = 0; mem_we = 1; mem_rd = 5'd3; #1;
    chk("lu_release", 32'(stall), 0);
    chk("lu_cause1", 32'(cause), 2'b01);
    chk("lu_cnt", 32'(cnt), 1);
    cyc();
    mem_we = 0; wb_we = 1; wb_rd = 5'd3; ex_rs = 10'd3; id_valid = 0; id_use = 0; #1;
    chk("lu_fwd_wb", 32'(fwd_sel[1:0]), 2'b11);
    chk("lu_cause2", 32'(cause), 0);
    wb_we = 0; ex_rs = '0; id_valid = 1; id_ll = 1; id_rd = 5'd9; #1;
    chk("ll_issue", 32'(stall), 0);
    cyc();
    id_ll = 0; id_use = 2'b01; id_rs = 10'd9; #1;
    chk("sb_stall1", 32'(stall), 1);
    cyc();
    chk("sb_cause", 32'(cause), 2'b10);
    chk("sb_stall2", 32'(stall), 1);
    cyc();
    ll_done = 1; ll_rd = 5'd9; #1;
    chk("sb_done_cyc", 32'(stall), 1);
    cyc();
    ll_done = 0; #1;
    chk("sb_release", 32'(stall), 0);
    chk("sb_cnt", 32'(cnt), 4);
    cyc();
    chk("sb_idle", 32'(cause), 0);
    id_use = 0; id_ll = 1; id_rd = 5'd1;
    cyc(); id_rd = 5'd2;
    cyc(); id_rd = 5'd3;
    cyc(); id_rd = 5'd4;
    cyc(); id_rd = 5'd5; #1;
    chk("full_flag", 32'(sb_full), 1);
    chk("full_stall", 32'(stall), 1);
    ll_done = 1; ll_rd = 5'd2; #1;
    chk("full_done_late", 32'(stall), 1);
    cyc();
    id_rd = 5'd2; #1;
    chk("full_freed", 32'(stall), 0);
    chk("full_clear", 32'(sb_full), 0);
    cyc();
    ll_done = 0; id_ll = 0; id_use = 2'b01; id_rs = 10'd2; #1;
    chk("issue_wins_full", 32'(sb_full), 1);
    chk("issue_wins_stall", 32'(stall), 1);
    cyc();
    chk("pre_rst_cause", 32'(cause), 2'b10);
    chk("pre_rst_cnt", 32'(cnt), 6);
    rst = 1;
    cyc();
    chk("mid_rst_stall", 32'(stall), 0);
    chk("mid_rst_cause", 32'(cause), 0);
    chk("mid_rst_cnt", 32'(cnt), 0);
    chk("mid_rst_full", 32'(sb_full), 0);
    rst = 0; #1;
    chk("post_rst_stall", 32'(stall), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

Parametrised forwarding and hazard controller for the 5-stage RV32I pipeline. It replaces the purely combinational EX-stage forwarding selector. Per-source forwarding now covers NUM_SRC operands plus a registered WB-hold bypass, and the block adds load-use stall detection, a scoreboard for long-latency (mul/div) writebacks, and a saturating stall counter. It sits beside the ID_EX / EX_MEM / MEM_WB registers and drives the EX operand muxes and the PC/IF_ID/ID_EX stall controls.

## Interface
- NUM_SRC, 2: source operands per instruction (2 or 3).
- XLEN, 32: data width.
- LL_MAX, 4: maximum outstanding long-latency writes (1..31).
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- EX_RSaddr_i  in  5*NUM_SRC  EX source register addresses; src k occupies [5k+4:5k].
- MEM_RegWrite_i, MEM_RDaddr_i  in  1, 5  EX_MEM write-back request.
- WB_RegWrite_i, WB_RDaddr_i, WB_data_i  in  1, 5, XLEN  MEM_WB write-back.
- ID_RSaddr_i  in  5*NUM_SRC  ID source addresses.
- ID_use_i  in  NUM_SRC  ID source k is actually read.
- ID_valid_i  in  1  ID holds a real instruction.
- ID_ll_i, ID_RDaddr_i  in  1, 5  ID instruction is long-latency, and its rd.
- EX_MemRead_i, EX_RDaddr_i  in  1, 5  EX holds a load, and its rd.
- LL_done_i, LL_RDaddr_i  in  1, 5  long-latency unit writing back rd this cycle.
- fwd_sel_o  out  2*NUM_SRC  per-source mux select; src k occupies [2k+1:2k].
- hold_data_o  out  XLEN  WB-hold bypass value.
- stall_o  out  1  freeze PC/IF_ID; insert bubble into ID_EX.
- stall_cause_o  out  2  FSM state: 00 IDLE, 01 LU, 10 SB.
- sb_full_o  out  1  pending count == LL_MAX.
- stall_cnt_o  out  16  saturating count of stalled cycles.

## Operation
- Forward select per source k, priority order, evaluated combinationally:
  - 10 when MEM_RegWrite_i, MEM_RDaddr_i≠0 and MEM_RDaddr_i==src.
  - 11 when WB_RegWrite_i, WB_RDaddr_i≠0 and WB_RDaddr_i==src.
  - 00 when hold_v, hold_addr≠0 and hold_addr==src.
  - otherwise 01 (register file).
- WB-hold register: on each cycle with WB_RegWrite_i && WB_RDaddr_i≠0, capture {addr, data} and set hold_v. With no such write, hold_v clears. It covers operands stalled across the regfile write edge.
- Load-use hit (lu_hit): EX_MemRead_i, EX_RDaddr_i≠0, and any k with ID_use_i[k] && ID_RSaddr k == EX_RDaddr_i.
- Scoreboard: pending[31:1] bits, pending[0] hard-wired 0. pcount = popcount(pending).
- sb_hit when ID_valid_i and any of these holds:
  - a used ID source is pending;
  - ID_ll_i with ID_RDaddr_i pending (WAW);
  - ID_ll_i with sb_full_o.
- stall_o = ID_valid_i && (lu_hit || sb_hit).
- Issue: ID_valid_i && ID_ll_i && !stall_o && ID_RDaddr_i≠0 sets pending[rd].
- Completion: LL_done_i clears pending[LL_RDaddr_i]. A done for an rd that is not pending is ignored.
- Issue and done to the same rd in the same cycle: issue wins, so the bit stays 1.
- A done that frees the last slot does not release an sb_full stall until the next cycle.
- FSM, registered next state:
  - IDLE→LU on lu_hit.
  - IDLE→SB on sb_hit && !lu_hit.
  - LU→IDLE unconditionally after one cycle.
  - SB→IDLE when !sb_hit; SB→LU on lu_hit.
  - lu_hit has priority over sb_hit.
- stall_cnt_o increments on every stall_o cycle and saturates at 16'hFFFF.

## Timing
- fwd_sel_o and stall_o are combinational from inputs and registered state, with zero latency.
- The hold register, pending bits, FSM and stall counter update on the rising edge of clk_i.
- An issue is visible as pending in the cycle after its issue edge. A done is visible as cleared in the cycle after its done edge.
- A load-use stall lasts exactly 1 cycle when the pipeline bubbles ID_EX. The dependent then sees fwd_sel 11 (WB).
- Reset takes priority over every other event, including a reset asserted mid-stall. Reset values:
  - pending=0, hold_v=0, FSM=IDLE, stall_cnt_o=0, sb_full_o=0, hold_data_o=0.
  - stall_o=0 while ID_valid_i=0.
  - fwd_sel_o=01 per source when inputs are idle.

## Structure
- Shared package fwd_pkg holds:
  - fwd_sel encodings FWD_RF=01, FWD_MEM=10, FWD_WB=11, FWD_HOLD=00;
  - stall cause encodings;
  - REG_AW=5.
- One natural sub-module, fwd_src_sel: the per-source priority compare, instantiated NUM_SRC times by generate.
- The scoreboard and FSM stay inline.

## Test plan
- MEM rd=5 and WB rd=5 both writing, EX src0=5 → fwd_sel[1:0]=10; with MEM_RegWrite_i=0 → 11; with MEM rd=0 and src0=0 → 01.
- WB writes x7=0xDEADBEEF; next cycle no write, EX src1=7 → fwd_sel[3:2]=00 and hold_data_o=0xDEADBEEF; one cycle later → 01.
- EX load to x3, ID uses x3 → stall_o=1 for one cycle, stall_cause_o=01, then 00; stall_cnt_o=1.
- Issue LL to x9; next ID reads x9 → stall_o held until LL_done_i(x9); stall_o=0 the cycle after done; stall_cnt_o equals the stall cycles.
- LL_MAX=4: issue to x1..x4 → sb_full_o=1 and a 5th LL issue stalls; done x2 with same-cycle issue x2 → x2 stays pending.
- Reset asserted during an SB stall → next cycle pending=0, FSM IDLE, stall_cnt_o=0, stall_o=0.
